// File: rtl/knob_table_loader.sv
// knob_table_loader: shadow/active value table loaded by valid/ready beats, committed atomically on the last beat.
module knob_table_loader #(
  parameter int NUM_KNOBS = 16,
  parameter int IDX_W     = 8,
  parameter int VAL_W     = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IDX_W-1:0] in_idx,
  input  logic [VAL_W-1:0] in_value,
  input  logic             in_last,
  input  logic             abort,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [VAL_W-1:0] rd_value,
  output logic             rd_exists,
  output logic             commit_pulse,
  output logic [IDX_W:0]   batch_count,
  output logic             err_range,
  output logic             err_dup
);
  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_LOAD   = 2'd1;
  localparam logic [1:0] S_COMMIT = 2'd2;
  logic [1:0]           state_q, state_d;
  logic [VAL_W-1:0]     active_q [NUM_KNOBS];
  logic [VAL_W-1:0]     active_d [NUM_KNOBS];
  logic [VAL_W-1:0]     shadow_q [NUM_KNOBS];
  logic [VAL_W-1:0]     shadow_d [NUM_KNOBS];
  logic [NUM_KNOBS-1:0] pending_q, pending_d, exists_q, exists_d;
  logic [IDX_W:0]       count_q, count_d;
  logic                 err_range_q, err_range_d;
  logic                 in_range;
  assign in_ready     = state_q != S_COMMIT;
  assign commit_pulse = state_q == S_COMMIT;
  assign batch_count  = count_q;
  assign err_range    = err_range_q;
  assign in_range     = {1'b0, in_idx} < (IDX_W+1)'(NUM_KNOBS);
  always_comb begin
    rd_value  = '0;
    rd_exists = 1'b0;
    for (int i = 0; i < NUM_KNOBS; i++)
      if (rd_idx == IDX_W'(i)) begin
        rd_value  = active_q[i];
        rd_exists = exists_q[i];
      end
  end
`ifdef KNOB_TABLE_LOADER_DUP_CHECK_EN
  logic err_dup_q, err_dup_d, dup;
  assign err_dup = err_dup_q;
`else
  assign err_dup = 1'b0;
`endif
  always_comb begin
    state_d     = state_q;
    active_d    = active_q;
    shadow_d    = shadow_q;
    pending_d   = pending_q;
    exists_d    = exists_q;
    count_d     = count_q;
    err_range_d = err_range_q;
`ifdef KNOB_TABLE_LOADER_DUP_CHECK_EN
    dup         = 1'b0;
`endif
    if (state_q == S_COMMIT) begin
      for (int i = 0; i < NUM_KNOBS; i++)
        if (pending_q[i]) active_d[i] = shadow_q[i];
      exists_d  = exists_q | pending_q;
      pending_d = '0;
      count_d   = '0;
      state_d   = S_IDLE;
    end else if (abort) begin
      pending_d = '0;
      count_d   = '0;
      state_d   = S_IDLE;
    end else if (in_valid) begin
      for (int i = 0; i < NUM_KNOBS; i++)
        if (in_idx == IDX_W'(i)) begin
          shadow_d[i]  = in_value;
          pending_d[i] = 1'b1;
`ifdef KNOB_TABLE_LOADER_DUP_CHECK_EN
          dup          = pending_q[i];
`endif
        end
      err_range_d = err_range_q | !in_range;
      count_d     = (in_range && count_q != '1) ? count_q + 1'b1 : count_q;
      state_d     = in_last ? S_COMMIT : S_LOAD;
    end
`ifdef KNOB_TABLE_LOADER_DUP_CHECK_EN
    err_dup_d = err_dup_q | dup;
`endif
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      active_q    <= '{default: '0};
      shadow_q    <= '{default: '0};
      pending_q   <= '0;
      exists_q    <= '0;
      count_q     <= '0;
      err_range_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      active_q    <= active_d;
      shadow_q    <= shadow_d;
      pending_q   <= pending_d;
      exists_q    <= exists_d;
      count_q     <= count_d;
      err_range_q <= err_range_d;
    end
  end
`ifdef KNOB_TABLE_LOADER_DUP_CHECK_EN
  always_ff @(posedge clk) err_dup_q <= reset ? 1'b0 : err_dup_d;
`endif
endmodule

// File: tb/tb_knob_table_loader.sv
// tb_knob_table_loader: directed scenario tests for knob_table_loader with hand-computed expectations.
module tb_knob_table_loader;
  logic        clk = 1'b0;
  logic        reset, in_valid, in_last, abort, in_ready, rd_exists, commit_pulse, err_range, err_dup;
  logic [7:0]  in_idx, rd_idx;
  logic [63:0] in_value, rd_value;
  logic [8:0]  batch_count;
  logic [63:0] exp_val [16];
  logic [15:0] exp_ex;
  int          errors = 0;
  int          checks = 0;
  knob_table_loader dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_idx(in_idx), .in_value(in_value), .in_last(in_last), .abort(abort),
    .rd_idx(rd_idx), .rd_value(rd_value), .rd_exists(rd_exists),
    .commit_pulse(commit_pulse), .batch_count(batch_count),
    .err_range(err_range), .err_dup(err_dup)
  );
  always #5 clk = ~clk;
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic beat(input logic [7:0] idx, input logic [63:0] val, input logic last);
    in_valid = 1'b1; in_idx = idx; in_value = val; in_last = last;
    step();
    in_valid = 1'b0; in_last = 1'b0;
  endtask
  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b0; in_last = 1'b0; abort = 1'b0;
    in_idx = '0; in_value = '0; rd_idx = 8'd5;
    step(); step();
    reset = 1'b0;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", in_ready); end
    checks++; if (commit_pulse !== 1'b0) begin errors++; $display("FAIL reset_commit got=%b exp=0", commit_pulse); end
    checks++; if (batch_count !== 9'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", batch_count); end
    checks++; if (err_range !== 1'b0 || err_dup !== 1'b0) begin errors++; $display("FAIL reset_err got=%b%b exp=00", err_range, err_dup); end
    checks++; if (rd_value !== 64'd0 || rd_exists !== 1'b0) begin errors++; $display("FAIL reset_rd got=%h/%b exp=0/0", rd_value, rd_exists); end
    for (int i = 0; i < 16; i++) exp_val[i] = '0;
    exp_ex = '0;
  endtask
  task automatic test_basic();
    beat(8'd2, 64'h11, 1'b0);
    beat(8'd5, 64'h22, 1'b0);
    checks++; if (batch_count !== 9'd2) begin errors++; $display("FAIL basic_count got=%0d exp=2", batch_count); end
    beat(8'd7, 64'h33, 1'b1);
    checks++; if (commit_pulse !== 1'b1 || in_ready !== 1'b0) begin errors++; $display("FAIL basic_commit got=%b/%b exp=1/0", commit_pulse, in_ready); end
    rd_idx = 8'd5;
    checks++; if (rd_value !== 64'd0) begin errors++; $display("FAIL basic_early got=%h exp=0", rd_value); end
    step();
    checks++; if (rd_value !== 64'h22 || rd_exists !== 1'b1) begin errors++; $display("FAIL basic_rd5 got=%h/%b exp=22/1", rd_value, rd_exists); end
    checks++; if (commit_pulse !== 1'b0 || batch_count !== 9'd0) begin errors++; $display("FAIL basic_after got=%b/%0d exp=0/0", commit_pulse, batch_count); end
    rd_idx = 8'd3; #1;
    checks++; if (rd_value !== 64'd0 || rd_exists !== 1'b0) begin errors++; $display("FAIL basic_rd3 got=%h/%b exp=0/0", rd_value, rd_exists); end
    exp_val[2] = 64'h11; exp_val[5] = 64'h22; exp_val[7] = 64'h33; exp_ex[2] = 1; exp_ex[5] = 1; exp_ex[7] = 1;
  endtask
  task automatic test_isolation();
    beat(8'd4, 64'hAA, 1'b0);
    rd_idx = 8'd4;
    for (int c = 0; c < 10; c++) begin
      checks++; if (rd_value !== 64'd0) begin errors++; $display("FAIL iso_hold cyc=%0d got=%h exp=0", c, rd_value); end
      step();
    end
    beat(8'd6, 64'hBB, 1'b1);
    in_valid = 1'b1; in_idx = 8'd8; in_value = 64'hCC; in_last = 1'b1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL iso_ready got=%b exp=0", in_ready); end
    step();
    checks++; if (rd_value !== 64'hAA || in_ready !== 1'b1) begin errors++; $display("FAIL iso_commit got=%h/%b exp=aa/1", rd_value, in_ready); end
    step();
    in_valid = 1'b0; in_last = 1'b0;
    checks++; if (commit_pulse !== 1'b1) begin errors++; $display("FAIL iso_held_commit got=%b exp=1", commit_pulse); end
    step();
    rd_idx = 8'd8; #1;
    checks++; if (rd_value !== 64'hCC || rd_exists !== 1'b1) begin errors++; $display("FAIL iso_held got=%h/%b exp=cc/1", rd_value, rd_exists); end
    exp_val[4] = 64'hAA; exp_val[6] = 64'hBB; exp_val[8] = 64'hCC; exp_ex[4] = 1; exp_ex[6] = 1; exp_ex[8] = 1;
  endtask
  task automatic test_dup();
    logic exp_dup;
`ifdef KNOB_TABLE_LOADER_DUP_CHECK_EN
    exp_dup = 1'b1;
`else
    exp_dup = 1'b0;
`endif
    checks++; if (err_dup !== 1'b0) begin errors++; $display("FAIL dup_pre got=%b exp=0", err_dup); end
    beat(8'd4, 64'h1, 1'b0);
    beat(8'd4, 64'h2, 1'b1);
    step();
    rd_idx = 8'd4; #1;
    checks++; if (rd_value !== 64'h2) begin errors++; $display("FAIL dup_value got=%h exp=2", rd_value); end
    checks++; if (err_dup !== exp_dup) begin errors++; $display("FAIL dup_flag got=%b exp=%b", err_dup, exp_dup); end
    exp_val[4] = 64'h2;
  endtask
  task automatic test_range();
    beat(8'd19, 64'hDEAD, 1'b1);
    checks++; if (commit_pulse !== 1'b1 || batch_count !== 9'd0 || err_range !== 1'b1) begin errors++; $display("FAIL range got=%b/%0d/%b exp=1/0/1", commit_pulse, batch_count, err_range); end
    step();
    rd_idx = 8'd19; #1;
    checks++; if (rd_value !== 64'd0 || rd_exists !== 1'b0) begin errors++; $display("FAIL range_rd got=%h/%b exp=0/0", rd_value, rd_exists); end
    for (int i = 0; i < 16; i++) begin
      rd_idx = 8'(i); #1;
      checks++; if (rd_value !== exp_val[i] || rd_exists !== exp_ex[i]) begin errors++; $display("FAIL range_table idx=%0d got=%h/%b exp=%h/%b", i, rd_value, rd_exists, exp_val[i], exp_ex[i]); end
    end
  endtask
  task automatic test_abort();
    beat(8'd1, 64'h5, 1'b0);
    beat(8'd2, 64'h6, 1'b0);
    abort = 1'b1; in_valid = 1'b1; in_idx = 8'd3; in_value = 64'h9; in_last = 1'b1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL abort_ready got=%b exp=1", in_ready); end
    step();
    abort = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    checks++; if (commit_pulse !== 1'b0 || batch_count !== 9'd0) begin errors++; $display("FAIL abort got=%b/%0d exp=0/0", commit_pulse, batch_count); end
    beat(8'd9, 64'h7, 1'b1);
    checks++; if (batch_count !== 9'd1) begin errors++; $display("FAIL abort_next_count got=%0d exp=1", batch_count); end
    step();
    exp_val[9] = 64'h7; exp_ex[9] = 1;
    for (int i = 0; i < 16; i++) begin
      rd_idx = 8'(i); #1;
      checks++; if (rd_value !== exp_val[i] || rd_exists !== exp_ex[i]) begin errors++; $display("FAIL abort_table idx=%0d got=%h/%b exp=%h/%b", i, rd_value, rd_exists, exp_val[i], exp_ex[i]); end
    end
  endtask
  task automatic test_reset_commit();
    beat(8'd0, 64'h55, 1'b1);
    checks++; if (commit_pulse !== 1'b1) begin errors++; $display("FAIL rstc_pulse got=%b exp=1", commit_pulse); end
    reset = 1'b1;
    step();
    reset = 1'b0;
    checks++; if (err_range !== 1'b0 || err_dup !== 1'b0 || commit_pulse !== 1'b0 || batch_count !== 9'd0) begin errors++; $display("FAIL rstc_state got=%b%b%b/%0d exp=000/0", err_range, err_dup, commit_pulse, batch_count); end
    for (int i = 0; i < 16; i++) begin
      rd_idx = 8'(i); #1;
      checks++; if (rd_value !== 64'd0 || rd_exists !== 1'b0) begin errors++; $display("FAIL rstc_table idx=%0d got=%h/%b exp=0/0", i, rd_value, rd_exists); end
    end
  endtask
  initial begin
    test_reset();
    test_basic();
    test_isolation();
    test_dup();
    test_range();
    test_abort();
    test_reset_commit();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
